// File: rtl/mem_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the memory port arbiter     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// +--------------------------------------------------------------------------+
// | rr_picker : combinational round-robin selector (first request at or      |
// |             after the pointer, wrapping modulo N)                        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_found
);

  logic [PTR_W-1:0] w_pos;

  function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return PTR_W'(s);
  endfunction

  // Scan from farthest to nearest so the nearest hit to the pointer is the one kept.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = f_wrap(i_ptr, k);
      if (i_req[w_pos]) begin
        o_grant        = '0;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
        o_found        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | mem_port_arbiter : round-robin sharing of one memory between NUM_REQ     |
// |                    requesters, one access in flight, stall watchdog      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                NUM_REQ  = 2,
  parameter int                TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [ADDR_W-1:0]         mem_in_addr,
  output logic [DATA_W-1:0]         mem_in_data,
  output logic                      mem_in_valid,
  input  logic                      mem_in_ready,
  output logic [ADDR_W-1:0]         mem_out_addr,
  output logic                      mem_out_valid,
  input  logic [DATA_W-1:0]         mem_out_data,
  input  logic                      mem_out_ready,
  output logic                      busy
);

  localparam int c_ptr_w = $clog2(NUM_REQ);
  localparam int c_tmr_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_tmr_w-1:0] c_tmo_last = (TIMEOUT > 0) ? c_tmr_w'(TIMEOUT - 1) : '0;
  localparam logic [c_ptr_w-1:0] c_last_req = c_ptr_w'(NUM_REQ - 1);

  state_t               r_state;
  logic [c_ptr_w-1:0]   r_rr_ptr;
  logic [c_ptr_w-1:0]   r_gnt;
  logic [c_tmr_w-1:0]   r_timer;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_data;
  logic [DATA_W-1:0]    r_rsp_data;
  logic                 r_rsp_err;

  logic [NUM_REQ-1:0]   w_grant;
  logic [c_ptr_w-1:0]   w_idx;
  logic                 w_found;
  logic                 w_mem_ready;
  logic                 w_expire;

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (c_ptr_w)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  assign w_mem_ready = (r_state == ST_WRITE) ? mem_in_ready : mem_out_ready;
  assign w_expire    = (TIMEOUT > 0) && (r_timer == c_tmo_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_gnt      <= '0;
      r_timer    <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_idx;
            r_addr  <= req_addr[w_idx*ADDR_W +: ADDR_W];
            r_data  <= req_data[w_idx*DATA_W +: DATA_W];
            r_timer <= '0;
            r_state <= req_write[w_idx] ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE, ST_READ: begin
          // A ready in the final watchdog cycle still completes normally.
          if (w_mem_ready) begin
            r_rsp_data <= (r_state == ST_READ) ? mem_out_data : '0;
            r_rsp_err  <= 1'b0;
            r_state    <= ST_RESP;
          end else if (w_expire) begin
            r_rsp_data <= (r_state == ST_READ) ? ERR_DATA : '0;
            r_rsp_err  <= 1'b1;
            r_state    <= ST_RESP;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[r_gnt]) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_rr_ptr <= (r_gnt == c_last_req) ? '0 : r_gnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Gating with reset keeps the accept pulse low while reset is held.
  assign req_ready     = (r_state == ST_IDLE && reset) ? w_grant : '0;
  assign rsp_valid     = (r_state == ST_RESP) ? (NUM_REQ'(1) << r_gnt) : '0;
  assign rsp_data      = r_rsp_data;
  assign rsp_err       = r_rsp_err;
  assign mem_in_valid  = (r_state == ST_WRITE);
  assign mem_in_addr   = r_addr;
  assign mem_in_data   = r_data;
  assign mem_out_valid = (r_state == ST_READ);
  assign mem_out_addr  = r_addr;
  assign busy          = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed bench with a transaction-level model      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  localparam int N   = 2;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req_valid = '0, req_write = '0, rsp_ready = '1;
  logic [N*32-1:0] req_addr = '0, req_data = '0;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [31:0]   rsp_data, mem_in_addr, mem_in_data, mem_out_addr;
  logic          rsp_err, mem_in_valid, mem_out_valid, busy;
  logic          mem_in_ready = 1'b0, mem_out_ready = 1'b0;
  logic [31:0]   mem_out_data = '0;

  mem_port_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready),
    .mem_in_addr(mem_in_addr), .mem_in_data(mem_in_data), .mem_in_valid(mem_in_valid),
    .mem_in_ready(mem_in_ready),
    .mem_out_addr(mem_out_addr), .mem_out_valid(mem_out_valid), .mem_out_data(mem_out_data),
    .mem_out_ready(mem_out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic expired(input string nm);
    n_chk++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  // Transaction-level reference: phase 0 = waiting for a request,
  // 1 = memory access outstanding, 2 = response offered.
  int          m_phase = 0, m_ptr = 0, m_g = 0, m_age = 0;
  bit          m_wr = 0, m_err = 0;
  logic [31:0] m_addr = '0, m_data = '0, m_rdata = '0;

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_ptr <= 0; m_age <= 0; m_err <= 0; m_rdata <= '0;
    end else if (m_phase == 0) begin
      if (pick() >= 0) begin
        m_g    <= pick();
        m_wr   <= req_write[pick()];
        m_addr <= req_addr[pick()*32 +: 32];
        m_data <= req_data[pick()*32 +: 32];
        m_age  <= 0;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (m_wr ? mem_in_ready : mem_out_ready) begin
        m_rdata <= m_wr ? 32'h0 : mem_out_data;
        m_err   <= 0;
        m_phase <= 2;
      end else if (m_age + 1 == TMO) begin
        m_rdata <= m_wr ? 32'h0 : 32'hDEAD_BEEF;
        m_err   <= 1;
        m_phase <= 2;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (rsp_ready[m_g]) begin
      m_ptr   <= (m_g + 1) % N;
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] e_rr;
    int p;
    e_rr = '0;
    p = pick();
    if (reset && m_phase == 0 && p >= 0) e_rr[p] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(e_rr));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("mem_in_valid", 32'(mem_in_valid), 32'(m_phase == 1 && m_wr));
    chk("mem_out_valid", 32'(mem_out_valid), 32'(m_phase == 1 && !m_wr));
    chk("rsp_valid", 32'(rsp_valid), (m_phase == 2) ? (32'd1 << m_g) : 32'd0);
    if (m_phase == 1 && m_wr) begin
      chk("mem_in_addr", mem_in_addr, m_addr);
      chk("mem_in_data", mem_in_data, m_data);
    end
    if (m_phase == 1 && !m_wr) chk("mem_out_addr", mem_out_addr, m_addr);
    if (m_phase == 2) begin
      chk("rsp_data", rsp_data, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
  end

  // Observation monitors feeding the directed literal checks.
  int          cyc = 0, rsp_cnt = 0, rsp_cyc = 0, rd_vcnt = 0;
  int          grant_log[$];
  logic [31:0] last_rsp_data = '0, last_in_addr = '0, last_out_addr = '0;
  logic        last_rsp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req_ready != '0) grant_log.push_back(req_ready[1] ? 1 : 0);
    if (mem_out_valid) begin rd_vcnt <= rd_vcnt + 1; last_out_addr <= mem_out_addr; end
    if (mem_in_valid) last_in_addr <= mem_in_addr;
    if (rsp_valid != '0) begin
      rsp_cnt <= rsp_cnt + 1; rsp_cyc <= cyc;
      last_rsp_data <= rsp_data; last_rsp_err <= rsp_err;
    end
  end

  // Memory: answers lat cycles after valid first appears, or never.
  logic [31:0] mem [0:255];
  int          mem_lat = 1;
  bit          mem_never = 0;

  initial begin
    int vcnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[4] = 32'h1234_5678;
    forever begin
      @(posedge clk); #1;
      mem_in_ready = 1'b0; mem_out_ready = 1'b0;
      if (mem_in_valid || mem_out_valid) begin
        vcnt++;
        if (!mem_never && vcnt == mem_lat + 1) begin
          if (mem_in_valid) begin
            mem[mem_in_addr[9:2]] = mem_in_data; mem_in_ready = 1'b1;
          end else begin
            mem_out_data = mem[mem_out_addr[9:2]]; mem_out_ready = 1'b1;
          end
        end
      end else vcnt = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input int r, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int lat);
    int t0, st;
    step();
    req_write[r] = wr; req_addr[r*32 +: 32] = a; req_data[r*32 +: 32] = d; req_valid[r] = 1'b1;
    t0 = cyc; st = rsp_cnt;
    step();
    req_valid[r] = 1'b0;
    for (int i = 0; i < 40 && rsp_cnt == st; i++) step();
    if (rsp_cnt == st) expired("do_req_rsp");
    lat = rsp_cyc - t0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) step();
    if (busy) expired("wait_idle");
  endtask

  initial begin
    int lat, g0, v0, c0;
    req_valid = 2'b11;
    repeat (3) step();
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_mem_valids", 32'({mem_in_valid, mem_out_valid}), 32'h0);
    chk("reset_rsp", 32'({rsp_valid, rsp_err}), 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    req_valid = '0;
    reset = 1'b1;

    mem_lat = 1;
    do_req(0, 1'b0, 32'h10, 32'h0, lat);
    chk("single_read_latency", 32'(lat), 32'd3);
    chk("single_read_data", last_rsp_data, 32'h1234_5678);
    chk("single_read_err", 32'(last_rsp_err), 32'h0);

    mem_lat = 2;
    do_req(1, 1'b1, 32'h40, 32'hCAFE_BABE, lat);
    chk("write_rsp_data", last_rsp_data, 32'h0);
    chk("write_rsp_err", 32'(last_rsp_err), 32'h0);
    chk("write_addr", last_in_addr, 32'h40);
    do_req(1, 1'b0, 32'h40, 32'h0, lat);
    chk("readback_data", last_rsp_data, 32'hCAFE_BABE);
    chk("readback_addr", last_out_addr, 32'h40);

    mem_lat = 0;
    grant_log.delete();
    step();
    req_write = '0; req_addr = {32'h24, 32'h20}; req_valid = 2'b11;
    for (int i = 0; i < 60 && grant_log.size() < 4; i++) step();
    req_valid = '0;
    wait_idle();
    if (grant_log.size() < 4) expired("rr_grants");
    else for (int k = 0; k < 4; k++) chk($sformatf("rr_order_%0d", k), 32'(grant_log[k]), 32'(k % 2));

    rsp_ready = 2'b10;
    step();
    req_addr = {32'h24, 32'h10}; req_valid = 2'b11;
    step();
    req_valid[0] = 1'b0;
    chk("rr_ptr_back_to_0", 32'(grant_log[grant_log.size()-1]), 32'd0);
    for (int i = 0; i < 20 && !rsp_valid[0]; i++) step();
    if (!rsp_valid[0]) expired("bp_rsp");
    g0 = grant_log.size();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_no_accept", 32'(req_ready), 32'h0);
      chk("bp_rsp_data", rsp_data, 32'h1234_5678);
      chk("bp_busy", 32'(busy), 32'h1);
    end
    chk("bp_grants", 32'(grant_log.size()), 32'(g0));
    rsp_ready = 2'b11;
    for (int i = 0; i < 10 && grant_log.size() == g0; i++) step();
    req_valid = '0;
    if (grant_log.size() == g0) expired("bp_next_grant");
    else chk("bp_next_grant", 32'(grant_log[grant_log.size()-1]), 32'd1);
    step();
    wait_idle();

    mem_never = 1;
    v0 = rd_vcnt;
    do_req(0, 1'b0, 32'h80, 32'h0, lat);
    chk("tmo_read_valid_cycles", 32'(rd_vcnt - v0), 32'd8);
    chk("tmo_read_err", 32'(last_rsp_err), 32'h1);
    chk("tmo_read_data", last_rsp_data, 32'hDEAD_BEEF);
    chk("tmo_read_latency", 32'(lat), 32'd9);
    do_req(1, 1'b1, 32'h44, 32'h1111_1111, lat);
    chk("tmo_write_err", 32'(last_rsp_err), 32'h1);
    chk("tmo_write_data", last_rsp_data, 32'h0);
    mem_never = 0; mem_lat = 7;
    do_req(0, 1'b0, 32'h10, 32'h0, lat);
    chk("last_cycle_ready_err", 32'(last_rsp_err), 32'h0);
    chk("last_cycle_ready_data", last_rsp_data, 32'h1234_5678);

    mem_never = 1;
    c0 = rsp_cnt;
    step();
    req_write[1] = 1'b0; req_addr[63:32] = 32'h10; req_valid[1] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    step();
    chk("pre_reset_read_valid", 32'(mem_out_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_valid", 32'(mem_out_valid), 32'h0);
    chk("async_reset_busy", 32'(busy), 32'h0);
    step(); step();
    reset = 1'b1;
    mem_never = 0; mem_lat = 0;
    chk("async_reset_no_rsp", 32'(rsp_cnt), 32'(c0));
    step();
    req_valid = 2'b11;
    step();
    req_valid = '0;
    chk("post_reset_ptr", 32'(grant_log[grant_log.size()-1]), 32'd0);
    wait_idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
